gcd_controller: RTL

Control FSM for the subtract-based GCD datapath. It consumes the datapath's `lt`, `gt` and `eq` compare flags and drives the `lda`, `ldb`, `sel1`, `sel2` and `sel_in` controls. It sequences operand loading from `data_in`, runs the subtract loop until the operands are equal, and reports completion to the host with a start/done handshake. An optional iteration watchdog catches non-terminating inputs such as a zero operand.

---
 rtl/gcd_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gcd_controller.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_controller
//  Description : Control FSM for a subtract-based GCD datapath. Loads two
//                operands from data_in, then repeatedly subtracts the smaller
//                register from the larger until the datapath reports equality,
//                and signals completion with a one-cycle done pulse.
//                Optional iteration watchdog enabled by defining the macro
//                GCD_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_controller #(
  parameter int MAX_ITER = 65535,
  parameter int ITER_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic lt,
  input  logic gt,
  input  logic eq,
  output logic lda,
  output logic ldb,
  output logic sel1,
  output logic sel2,
  output logic sel_in,
  output logic busy,
  output logic data_req,
  output logic done,
  output logic error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CALC   = 3'd3,
    S_DONE   = 3'd4
`ifdef GCD_TIMEOUT_EN
    , S_ERR  = 3'd5
`endif
  } state_t;

  state_t r_state;

  // Exactly one compare flag must be set for a subtract; anything else is
  // treated as equality so the FSM can never loop on a corrupt compare.
  logic w_one_hot;
  logic w_sub_a;
  logic w_sub_b;
  logic w_at_limit;

  assign w_one_hot = (lt & ~gt & ~eq) | (~lt & gt & ~eq) | (~lt & ~gt & eq);
  assign w_sub_a   = w_one_hot & gt;
  assign w_sub_b   = w_one_hot & lt;

`ifdef GCD_TIMEOUT_EN
  localparam logic [ITER_W-1:0] c_max_iter = ITER_W'(MAX_ITER);

  logic [ITER_W-1:0] r_iter;

  assign w_at_limit = (r_iter == c_max_iter);

  // Iteration counter: cleared while B loads, counts each subtract cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iter <= '0;
    end else if (r_state == S_LOAD_B) begin
      r_iter <= '0;
    end else if (r_state == S_CALC && (w_sub_a || w_sub_b) && !w_at_limit) begin
      r_iter <= r_iter + ITER_W'(1);
    end
  end
`else
  assign w_at_limit = 1'b0;
`endif

  // State register: sequence load, subtract loop and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD_A;
          end
        end
        S_LOAD_A: r_state <= S_LOAD_B;
        S_LOAD_B: r_state <= S_CALC;
        S_CALC: begin
          if (!(w_sub_a || w_sub_b)) begin
            r_state <= S_DONE;
          end else if (w_at_limit) begin
`ifdef GCD_TIMEOUT_EN
            r_state <= S_ERR;
`else
            r_state <= S_CALC;
`endif
          end else begin
            r_state <= S_CALC;
          end
        end
        S_DONE: r_state <= S_IDLE;
`ifdef GCD_TIMEOUT_EN
        S_ERR:  r_state <= S_IDLE;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode from the state and live compare flags; no output latency.
  always_comb begin
    lda      = 1'b0;
    ldb      = 1'b0;
    sel1     = 1'b0;
    sel2     = 1'b0;
    sel_in   = 1'b0;
    data_req = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_LOAD_A: begin
        sel_in   = 1'b1;
        lda      = 1'b1;
        data_req = 1'b1;
      end
      S_LOAD_B: begin
        sel_in   = 1'b1;
        ldb      = 1'b1;
        data_req = 1'b1;
      end
      S_CALC: begin
        // A <- A - B
        if (w_sub_a && !w_at_limit) begin
          lda  = 1'b1;
          sel2 = 1'b1;
        end
        // B <- B - A
        if (w_sub_b && !w_at_limit) begin
          ldb  = 1'b1;
          sel1 = 1'b1;
        end
      end
      S_DONE: done = 1'b1;
`ifdef GCD_TIMEOUT_EN
      S_ERR:  error = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire
